id_ex_pipe_reg: RTL and testbench

ID/EX pipeline register for the pipelined MIPS datapath. It captures the decode-stage results: PC+4, both register-file read values, the 32-bit sign-extended immediate from the sign-extend unit, register addresses and the decoded control word. It presents them to the execute stage one cycle later. It supports hazard-unit stall (hold) and flush (bubble insertion) so that load-use and branch hazards resolve without corrupting EX.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/id_ex_pipe_reg_if.sv | 46 ++++
 rtl/pipe_field_reg.sv | 21 ++
 rtl/id_ex_pipe_reg.sv | 69 ++++++
 tb/tb_id_ex_pipe_reg.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control word width, control bit positions and type.
// Used by every pipeline register (IF/ID, ID/EX, EX/MEM).
package cpu_pkg;
   localparam int CTRL_W     = 10;

   localparam int REG_WRITE  = 0;
   localparam int MEM_TO_REG = 1;
   localparam int MEM_READ   = 2;
   localparam int MEM_WRITE  = 3;
   localparam int BRANCH     = 4;
   localparam int ALU_SRC    = 5;
   localparam int REG_DST    = 6;
   localparam int ALU_OP_LO  = 7;
   localparam int ALU_OP_HI  = 9;

   typedef logic [CTRL_W-1:0] ctrl_t;

   // True when the control word can change architectural state.
   function automatic logic ctrl_has_side_effect(input ctrl_t c);
      return c[REG_WRITE] | c[MEM_WRITE];
   endfunction
endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX pipeline register bus: hazard controls, decode-stage inputs, EX-stage outputs.
// master = ID stage / hazard unit side, slave = the pipeline register.
interface id_ex_pipe_reg_if #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5,
   parameter int CTRL_W  = cpu_pkg::CTRL_W
);
   logic               stall_i;
   logic               flush_i;
   logic               valid_i;
   logic [DATA_W-1:0]  pc_plus4_i;
   logic [DATA_W-1:0]  rs_data_i;
   logic [DATA_W-1:0]  rt_data_i;
   logic [DATA_W-1:0]  imm_i;
   logic [RADDR_W-1:0] rs_addr_i;
   logic [RADDR_W-1:0] rt_addr_i;
   logic [RADDR_W-1:0] rd_addr_i;
   logic [4:0]         shamt_i;
   logic [CTRL_W-1:0]  ctrl_i;

   logic               valid_o;
   logic [DATA_W-1:0]  pc_plus4_o;
   logic [DATA_W-1:0]  rs_data_o;
   logic [DATA_W-1:0]  rt_data_o;
   logic [DATA_W-1:0]  imm_o;
   logic [RADDR_W-1:0] rs_addr_o;
   logic [RADDR_W-1:0] rt_addr_o;
   logic [RADDR_W-1:0] rd_addr_o;
   logic [4:0]         shamt_o;
   logic [CTRL_W-1:0]  ctrl_o;
   logic [15:0]        bubble_cnt_o;

   modport master (
      output stall_i, flush_i, valid_i, pc_plus4_i, rs_data_i, rt_data_i, imm_i,
             rs_addr_i, rt_addr_i, rd_addr_i, shamt_i, ctrl_i,
      input  valid_o, pc_plus4_o, rs_data_o, rt_data_o, imm_o,
             rs_addr_o, rt_addr_o, rd_addr_o, shamt_o, ctrl_o, bubble_cnt_o
   );

   modport slave (
      input  stall_i, flush_i, valid_i, pc_plus4_i, rs_data_i, rt_data_i, imm_i,
             rs_addr_i, rt_addr_i, rd_addr_i, shamt_i, ctrl_i,
      output valid_o, pc_plus4_o, rs_data_o, rt_data_o, imm_o,
             rs_addr_o, rt_addr_o, rd_addr_o, shamt_o, ctrl_o, bubble_cnt_o
   );
endinterface

// File: rtl/pipe_field_reg.sv
// One pipeline field: sync active-low reset, flush clears, stall holds, else load.
module pipe_field_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] d_i,
   output logic [DATA_W-1:0] q_o
);
   logic [DATA_W-1:0] r_q;

   always_ff @(posedge clk_i) begin
      if (!rst_i)        r_q <= '0;
      else if (flush_i)  r_q <= '0;
      else if (!stall_i) r_q <= d_i;
   end

   assign q_o = r_q;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: per-field registers with stall/flush plus a
// saturating count of flush-inserted bubbles.
module id_ex_pipe_reg
   import cpu_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5,
   parameter int CTRL_W  = cpu_pkg::CTRL_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   id_ex_pipe_reg_if.slave  bus
);
   logic [CTRL_W-1:0] w_ctrl_d;
   logic [15:0]       r_bubble_cnt;

   // An invalid ID slot must not carry enables into EX.
   assign w_ctrl_d = bus.valid_i ? bus.ctrl_i : '0;

   pipe_field_reg #(.DATA_W(1)) u_valid (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(bus.stall_i), .flush_i(bus.flush_i),
      .d_i(bus.valid_i), .q_o(bus.valid_o));

   pipe_field_reg #(.DATA_W(DATA_W)) u_pc (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(bus.stall_i), .flush_i(bus.flush_i),
      .d_i(bus.pc_plus4_i), .q_o(bus.pc_plus4_o));

   pipe_field_reg #(.DATA_W(DATA_W)) u_rs_data (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(bus.stall_i), .flush_i(bus.flush_i),
      .d_i(bus.rs_data_i), .q_o(bus.rs_data_o));

   pipe_field_reg #(.DATA_W(DATA_W)) u_rt_data (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(bus.stall_i), .flush_i(bus.flush_i),
      .d_i(bus.rt_data_i), .q_o(bus.rt_data_o));

   pipe_field_reg #(.DATA_W(DATA_W)) u_imm (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(bus.stall_i), .flush_i(bus.flush_i),
      .d_i(bus.imm_i), .q_o(bus.imm_o));

   pipe_field_reg #(.DATA_W(RADDR_W)) u_rs_addr (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(bus.stall_i), .flush_i(bus.flush_i),
      .d_i(bus.rs_addr_i), .q_o(bus.rs_addr_o));

   pipe_field_reg #(.DATA_W(RADDR_W)) u_rt_addr (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(bus.stall_i), .flush_i(bus.flush_i),
      .d_i(bus.rt_addr_i), .q_o(bus.rt_addr_o));

   pipe_field_reg #(.DATA_W(RADDR_W)) u_rd_addr (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(bus.stall_i), .flush_i(bus.flush_i),
      .d_i(bus.rd_addr_i), .q_o(bus.rd_addr_o));

   pipe_field_reg #(.DATA_W(5)) u_shamt (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(bus.stall_i), .flush_i(bus.flush_i),
      .d_i(bus.shamt_i), .q_o(bus.shamt_o));

   pipe_field_reg #(.DATA_W(CTRL_W)) u_ctrl (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(bus.stall_i), .flush_i(bus.flush_i),
      .d_i(w_ctrl_d), .q_o(bus.ctrl_o));

   // Counts flushes only; a load with valid_i=0 is not a bubble here.
   always_ff @(posedge clk_i) begin
      if (!rst_i)
         r_bubble_cnt <= '0;
      else if (bus.flush_i && (r_bubble_cnt != 16'hFFFF))
         r_bubble_cnt <= r_bubble_cnt + 16'd1;
   end

   assign bus.bubble_cnt_o = r_bubble_cnt;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboarded bench for id_ex_pipe_reg: a reference model predicts the outputs
// after each edge, a negedge monitor compares; directed checks cover the test plan.
module tb_id_ex_pipe_reg;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [4:0]  rsa;
      logic [4:0]  rta;
      logic [4:0]  rda;
      logic [4:0]  shamt;
      logic [9:0]  ctrl;
      logic [15:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   exp_t m = '0;
   int   model_cnt = 0;

   always #5 clk = ~clk;

   id_ex_pipe_reg_if bus ();

   id_ex_pipe_reg dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

   // Reference: what the EX stage should see after this edge.
   always @(posedge clk) begin
      if (!rst_n) begin
         m = '0;
         model_cnt = 0;
      end else if (bus.flush_i) begin
         model_cnt = (model_cnt + 1 > 65535) ? 65535 : model_cnt + 1;
         m = '0;
         m.cnt = model_cnt[15:0];
      end else if (!bus.stall_i) begin
         m.valid = bus.valid_i;
         m.pc    = bus.pc_plus4_i;
         m.rs    = bus.rs_data_i;
         m.rt    = bus.rt_data_i;
         m.imm   = bus.imm_i;
         m.rsa   = bus.rs_addr_i;
         m.rta   = bus.rt_addr_i;
         m.rda   = bus.rd_addr_i;
         m.shamt = bus.shamt_i;
         m.ctrl  = bus.valid_i ? bus.ctrl_i : 10'd0;
      end
      q.push_back(m);
   end

   always @(negedge clk) begin
      exp_t e, a;
      if (q.size() > 0) begin
         e = q.pop_front();
         a = {bus.valid_o, bus.pc_plus4_o, bus.rs_data_o, bus.rt_data_o, bus.imm_o,
              bus.rs_addr_o, bus.rt_addr_o, bus.rd_addr_o, bus.shamt_o, bus.ctrl_o,
              bus.bubble_cnt_o};
         checks++;
         if (a !== e) begin
            errors++;
            if (errors < 20)
               $display("FAIL scoreboard t=%0t got %h expected %h", $time, a, e);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic set_all(input logic [31:0] v);
      bus.pc_plus4_i = v; bus.rs_data_i = v; bus.rt_data_i = v; bus.imm_i = v;
      bus.rs_addr_i = v[4:0]; bus.rt_addr_i = v[4:0]; bus.rd_addr_i = v[4:0];
      bus.shamt_i = v[4:0]; bus.ctrl_i = v[9:0];
   endtask

   task automatic rnd_in();
      bus.pc_plus4_i = $urandom; bus.rs_data_i = $urandom; bus.rt_data_i = $urandom;
      bus.imm_i = $urandom; bus.rs_addr_i = 5'($urandom); bus.rt_addr_i = 5'($urandom);
      bus.rd_addr_i = 5'($urandom); bus.shamt_i = 5'($urandom); bus.ctrl_i = 10'($urandom);
      bus.valid_i = ($urandom_range(0, 3) != 0);
      bus.stall_i = ($urandom_range(0, 4) == 0);
      bus.flush_i = ($urandom_range(0, 6) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
   endtask

   initial begin
      set_all(32'hFFFF_FFFF);
      bus.valid_i = 1'b1; bus.stall_i = 1'b1; bus.flush_i = 1'b1;
      rst_n = 1'b0;
      tick();
      chk("rst_valid", {31'd0, bus.valid_o}, 32'd0);
      chk("rst_pc", bus.pc_plus4_o, 32'd0);
      chk("rst_ctrl", {22'd0, bus.ctrl_o}, 32'd0);
      chk("rst_cnt", {16'd0, bus.bubble_cnt_o}, 32'd0);
      tick();
      chk("rst_hold_imm", bus.imm_o, 32'd0);
      chk("rst_hold_cnt", {16'd0, bus.bubble_cnt_o}, 32'd0);

      rst_n = 1'b1; bus.stall_i = 1'b0; bus.flush_i = 1'b0; set_all(32'd0);
      bus.imm_i = 32'hFFFF_8000; bus.rs_data_i = 32'h1234_5678; bus.ctrl_i = 10'h021;
      bus.valid_i = 1'b1;
      tick();
      chk("load_imm", bus.imm_o, 32'hFFFF_8000);
      chk("load_rs", bus.rs_data_o, 32'h1234_5678);
      chk("load_ctrl", {22'd0, bus.ctrl_o}, 32'h021);
      chk("load_valid", {31'd0, bus.valid_o}, 32'd1);

      bus.pc_plus4_i = 32'h10;
      tick();
      chk("stall_cap", bus.pc_plus4_o, 32'h10);
      bus.stall_i = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         bus.pc_plus4_i = 32'h10 + 32'(4 * i);
         tick();
         chk("stall_hold", bus.pc_plus4_o, 32'h10);
      end
      bus.stall_i = 1'b0; bus.pc_plus4_i = 32'h20;
      tick();
      chk("stall_release", bus.pc_plus4_o, 32'h20);

      bus.flush_i = 1'b1; bus.stall_i = 1'b1; bus.ctrl_i = 10'h3FF;
      tick();
      chk("flush_ctrl", {22'd0, bus.ctrl_o}, 32'd0);
      chk("flush_valid", {31'd0, bus.valid_o}, 32'd0);
      chk("flush_cnt", {16'd0, bus.bubble_cnt_o}, 32'd1);
      chk("flush_pc", bus.pc_plus4_o, 32'd0);

      bus.flush_i = 1'b0; bus.stall_i = 1'b0; bus.ctrl_i = 10'h00F; bus.valid_i = 1'b0;
      bus.rs_data_i = 32'h0000_ABCD;
      tick();
      chk("inv_ctrl", {22'd0, bus.ctrl_o}, 32'd0);
      chk("inv_valid", {31'd0, bus.valid_o}, 32'd0);
      chk("inv_cnt", {16'd0, bus.bubble_cnt_o}, 32'd1);
      chk("inv_rs", bus.rs_data_o, 32'h0000_ABCD);

      for (int i = 0; i < 3000; i++) begin
         rnd_in();
         tick();
      end

      rst_n = 1'b0; bus.flush_i = 1'b0; bus.stall_i = 1'b0;
      tick();
      chk("sat_start", {16'd0, bus.bubble_cnt_o}, 32'd0);
      rst_n = 1'b1; bus.flush_i = 1'b1;
      for (int i = 0; i < 65536; i++) tick();
      chk("sat_reach", {16'd0, bus.bubble_cnt_o}, 32'h0000_FFFF);
      tick();
      chk("sat_stay", {16'd0, bus.bubble_cnt_o}, 32'h0000_FFFF);
      rst_n = 1'b0;
      tick();
      chk("sat_reset", {16'd0, bus.bubble_cnt_o}, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("post_reset_flush", {16'd0, bus.bubble_cnt_o}, 32'd1);
      bus.flush_i = 1'b0;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
